// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared cell type, respawn FSM states and reset defaults
package snake_pkg;

  localparam int SNAKE_GRID_BITS = 4;
  localparam int SNAKE_INIT_X    = 12;
  localparam int SNAKE_INIT_Y    = 5;

  typedef struct packed {
    logic [SNAKE_GRID_BITS-1:0] x;
    logic [SNAKE_GRID_BITS-1:0] y;
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_SCAN   = 2'd2,
    ST_COMMIT = 2'd3
  } spawn_state_e;

endpackage

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - two-flop synchronizer for a single asynchronous level
module synchronizer (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/apple_spawner.sv
// rtl/apple_spawner.sv - apple placement, eat detection and body-avoiding respawn engine
module apple_spawner
  import snake_pkg::*;
#(
  parameter int GRID_BITS  = SNAKE_GRID_BITS,
  parameter int MAX_LEN    = 50,
  parameter int NUM_APPLES = 2,
  parameter int MAX_RETRY  = 15,
  parameter int INIT_X     = SNAKE_INIT_X,
  parameter int INIT_Y     = SNAKE_INIT_Y
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             s_reset,
  input  logic [GRID_BITS-1:0]             x,
  input  logic [GRID_BITS-1:0]             y,
  input  logic [GRID_BITS-1:0]             head_x,
  input  logic [GRID_BITS-1:0]             head_y,
  input  logic [GRID_BITS-1:0]             randX,
  input  logic [GRID_BITS-1:0]             randY,
  input  logic                             goodColl,
  input  logic [MAX_LEN*2*GRID_BITS-1:0]   body,
  input  logic [$clog2(MAX_LEN+1)-1:0]     body_len,
  output logic                             apple,
  output logic [NUM_APPLES-1:0]            apple_valid,
  output logic                             eaten,
  output logic                             busy
);

  localparam int CW = 2 * GRID_BITS;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int AW = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

  spawn_state_e          r_state;
  spawn_state_e          w_next;
  logic [CW-1:0]         r_cell [NUM_APPLES];
  logic [NUM_APPLES-1:0] r_valid;
  logic [NUM_APPLES-1:0] r_pending;
  logic [CW-1:0]         r_cand;
  logic [LW-1:0]         r_scan_idx;
  logic [RW-1:0]         r_retry;
  logic [AW-1:0]         r_srv;
  logic                  r_sync_prev;
  logic                  r_edge;
  logic                  r_eaten;
  logic                  r_apple;

  logic                  w_resetn;
  logic                  w_sync;
  logic [CW-1:0]         w_head;
  logic [CW-1:0]         w_scan;
  logic [CW-1:0]         w_rand;
  logic [CW-1:0]         w_slot;
  logic                  w_body_hit;
  logic                  w_scan_last;
  logic                  w_conflict;
  logic                  w_commit_ok;
  logic                  w_busy;
  logic                  w_eat_hit;
  logic                  w_render;
  logic [AW-1:0]         w_pend_idx;
  logic [NUM_APPLES-1:0] w_eat_mask;
  logic [NUM_APPLES-1:0] w_commit_mask;

  assign w_resetn = reset & ~s_reset;
  assign w_head   = {head_x, head_y};
  assign w_scan   = {x, y};
  assign w_rand   = {randX, randY};

  synchronizer u_sync (
    .i_clk    (clk),
    .i_resetn (w_resetn),
    .i_d      (goodColl),
    .o_q      (w_sync)
  );

  // Lowest-index valid apple under the head wins when several share a cell.
  always_comb begin
    w_eat_mask = '0;
    if (r_edge) begin
      for (int i = NUM_APPLES - 1; i >= 0; i--) begin
        if (r_valid[i] && (r_cell[i] == w_head)) begin
          w_eat_mask    = '0;
          w_eat_mask[i] = 1'b1;
        end
      end
    end
    w_eat_hit = |w_eat_mask;
  end

  always_comb begin
    w_pend_idx = '0;
    for (int i = NUM_APPLES - 1; i >= 0; i--) begin
      if (r_pending[i]) w_pend_idx = AW'(i);
    end
  end

  always_comb begin
    w_slot = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (r_scan_idx == LW'(k)) w_slot = body[k*CW +: CW];
    end
    w_body_hit  = (body_len != '0) && (w_slot == r_cand);
    w_scan_last = (body_len == '0) || (r_scan_idx == body_len - LW'(1));
  end

  always_comb begin
    w_conflict = (r_cand == w_head);
    for (int j = 0; j < NUM_APPLES; j++) begin
      if ((AW'(j) != r_srv) && r_valid[j] && (r_cell[j] == r_cand)) w_conflict = 1'b1;
    end
  end

  always_comb begin
    w_render = 1'b0;
    for (int i = 0; i < NUM_APPLES; i++) begin
      if (r_valid[i] && (r_cell[i] == w_scan)) w_render = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_resetn) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (|r_pending) w_next = ST_DRAW;
      ST_DRAW:   w_next = ST_SCAN;
      ST_SCAN:   begin
        if (w_body_hit)       w_next = ST_DRAW;
        else if (w_scan_last) w_next = ST_COMMIT;
      end
      ST_COMMIT: w_next = w_conflict ? ST_DRAW : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (r_state != ST_IDLE);
    w_commit_ok   = (r_state == ST_COMMIT) && !w_conflict;
    w_commit_mask = '0;
    for (int i = 0; i < NUM_APPLES; i++) begin
      if (AW'(i) == r_srv) w_commit_mask[i] = w_commit_ok;
    end
  end

  // Once retries saturate, the draw walks linearly from the last rejected cell.
  always_ff @(posedge clk) begin
    if (!w_resetn) begin
      r_cand     <= '0;
      r_scan_idx <= '0;
      r_retry    <= '0;
      r_srv      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (|r_pending) begin
          r_retry <= '0;
          r_srv   <= w_pend_idx;
        end
        ST_DRAW: begin
          r_cand     <= (r_retry == RW'(MAX_RETRY)) ? r_cand + CW'(1) : w_rand;
          r_scan_idx <= '0;
        end
        ST_SCAN: begin
          if (w_body_hit) begin
            if (r_retry != RW'(MAX_RETRY)) r_retry <= r_retry + RW'(1);
          end else begin
            r_scan_idx <= r_scan_idx + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!w_resetn) begin
      for (int i = 0; i < NUM_APPLES; i++) begin
        r_cell[i] <= {GRID_BITS'(INIT_X), GRID_BITS'(INIT_Y + 2 * i)};
      end
      r_valid     <= '1;
      r_pending   <= '0;
      r_sync_prev <= 1'b0;
      r_edge      <= 1'b0;
      r_eaten     <= 1'b0;
      r_apple     <= 1'b0;
    end else begin
      r_sync_prev <= w_sync;
      r_edge      <= w_sync & ~r_sync_prev;
      r_eaten     <= w_eat_hit;
      r_valid     <= (r_valid | w_commit_mask) & ~w_eat_mask;
      r_pending   <= (r_pending | w_eat_mask) & ~w_commit_mask;
      for (int i = 0; i < NUM_APPLES; i++) begin
        if (w_commit_mask[i]) r_cell[i] <= r_cand;
      end
      r_apple     <= w_render;
    end
  end

  assign apple       = r_apple;
  assign apple_valid = r_valid;
  assign eaten       = r_eaten;
  assign busy        = w_busy;

endmodule

// File: tb/tb_apple_spawner.sv
// tb/tb_apple_spawner.sv - randomized self-checking bench for apple_spawner
module tb_apple_spawner;
  import snake_pkg::*;

  localparam int G  = 4;
  localparam int ML = 50;
  localparam int NA = 2;
  localparam int MR = 15;
  localparam int LW = $clog2(ML + 1);

  logic            clk = 1'b0;
  logic            reset, s_reset, goodColl;
  logic [G-1:0]    x, y, head_x, head_y, randX, randY;
  logic [ML*2*G-1:0] body;
  logic [LW-1:0]   body_len;
  logic            apple, eaten, busy;
  logic [NA-1:0]   apple_valid;

  always #5 clk = ~clk;

  apple_spawner #(
    .GRID_BITS(G), .MAX_LEN(ML), .NUM_APPLES(NA), .MAX_RETRY(MR), .INIT_X(12), .INIT_Y(5)
  ) dut (
    .clk(clk), .reset(reset), .s_reset(s_reset), .x(x), .y(y),
    .head_x(head_x), .head_y(head_y), .randX(randX), .randY(randY),
    .goodColl(goodColl), .body(body), .body_len(body_len),
    .apple(apple), .apple_valid(apple_valid), .eaten(eaten), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference state: where apples are, and which are present.
  cell_t         m_cell [NA];
  logic [NA-1:0] m_valid;
  cell_t         m_body [ML];
  int            m_len;

  task automatic model_reset;
    for (int i = 0; i < NA; i++) begin
      m_cell[i].x = G'(12);
      m_cell[i].y = G'((5 + 2 * i) % 16);
    end
    m_valid = '1;
  endtask

  function automatic bit model_apple(input cell_t c);
    for (int i = 0; i < NA; i++) if (m_valid[i] && m_cell[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit occupied(input cell_t c);
    for (int k = 0; k < m_len; k++) if (m_body[k] == c) return 1'b1;
    if (c == {head_x, head_y}) return 1'b1;
    return model_apple(c);
  endfunction

  function automatic cell_t pick_free();
    cell_t c;
    do c = 8'($urandom_range(0, 255)); while (occupied(c));
    return c;
  endfunction

  task automatic make_body(input int len);
    cell_t c;
    bit    dup;
    m_len = 0;
    while (m_len < len) begin
      c = 8'($urandom_range(0, 255));
      dup = model_apple(c);
      for (int k = 0; k < m_len; k++) if (m_body[k] == c) dup = 1'b1;
      if (!dup) begin
        m_body[m_len] = c;
        m_len++;
      end
    end
    body = '0;
    for (int k = 0; k < m_len; k++) body[k*8 +: 8] = m_body[k];
    body_len = LW'(m_len);
  endtask

  task automatic set_head(input cell_t c);
    head_x = c.x;
    head_y = c.y;
  endtask

  task automatic set_rand(input cell_t c);
    randX = c.x;
    randY = c.y;
  endtask

  task automatic probe(input string tag, input cell_t c);
    x = c.x;
    y = c.y;
    tick();
    check(tag, apple, model_apple(c));
  endtask

  task automatic render_scan;
    cell_t c;
    for (int xx = 0; xx < 16; xx++) begin
      for (int yy = 0; yy < 16; yy++) begin
        c.x = G'(xx);
        c.y = G'(yy);
        probe("render", c);
      end
    end
  endtask

  // Eat apple ai (head already on it), expect it back at exp_cell after exp_lat cycles of busy.
  task automatic eat_round(input int ai, input cell_t exp_cell, input int exp_lat);
    int    cyc;
    cell_t old;
    old = m_cell[ai];
    goodColl = 1'b1;
    cyc = 0;
    while (cyc < 20 && !eaten) begin
      tick();
      cyc++;
    end
    check("eat_latency", cyc, 4);
    m_valid[ai] = 1'b0;
    check("eat_valid_cleared", apple_valid, m_valid);
    goodColl = 1'b0;
    tick();
    check("eaten_one_cycle", eaten, 0);
    check("busy_rise", busy, 1);
    cyc = 0;
    while (cyc < 3000 && !apple_valid[ai]) begin
      tick();
      cyc++;
    end
    check("respawn_latency", cyc, exp_lat);
    m_valid[ai] = 1'b1;
    m_cell[ai]  = exp_cell;
    check("respawn_valid", apple_valid, m_valid);
    check("busy_after_commit", busy, 0);
    probe("new_cell", exp_cell);
    probe("old_cell", old);
  endtask

  cell_t r_c, r1_c, a0, a1, b_c;
  logic [7:0] cv;
  int    len, ai, lat, hit_k, t, n_eat, t_eat1, t_eat2, t_v0, t_v1;
  bit    conflict;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; s_reset = 1'b0; goodColl = 1'b0;
    x = '0; y = '0; head_x = '0; head_y = '0; randX = '0; randY = '0;
    m_valid = '1;
    model_reset();
    make_body(0);
    tick();
    tick();
    check("reset_valid", apple_valid, 2'b11);
    check("reset_busy", busy, 0);
    check("reset_eaten", eaten, 0);
    check("reset_apple", apple, 0);
    reset = 1'b1;
    tick();
    render_scan();

    // Free first draw: apple returns after DRAW + SCAN + COMMIT.
    for (int r = 0; r < 8; r++) begin
      ai  = (r == 0) ? 0 : int'($urandom_range(0, NA - 1));
      len = (r == 0) ? 3 : (r == 1) ? 0 : (r == 2) ? 1 : int'($urandom_range(0, 12));
      make_body(len);
      set_head(m_cell[ai]);
      r_c = pick_free();
      set_rand(r_c);
      eat_round(ai, r_c, 2 + ((len > 0) ? len : 1));
      repeat (3) tick();
    end

    // A collision edge away from every apple changes nothing.
    set_head(pick_free());
    goodColl = 1'b1;
    n_eat = 0;
    repeat (10) begin
      tick();
      if (eaten) n_eat++;
    end
    goodColl = 1'b0;
    check("ignored_eaten", n_eat, 0);
    check("ignored_valid", apple_valid, m_valid);
    check("ignored_busy", busy, 0);
    repeat (4) tick();

    // Random source stuck on body[2]: retries exhaust, then linear walk from it.
    make_body(5);
    b_c = m_body[2];
    set_head(m_cell[0]);
    set_rand(b_c);
    lat = MR * 4;
    cv  = b_c;
    for (int n = 0; n < 300; n++) begin
      cv = cv + 8'd1;
      hit_k = -1;
      for (int k = m_len - 1; k >= 0; k--) if (m_body[k] == cv) hit_k = k;
      if (hit_k >= 0) begin
        lat += 2 + hit_k;
      end else begin
        lat += 2 + m_len;
        conflict = (cv == m_cell[0]) || (m_valid[1] && m_cell[1] == cv);
        if (!conflict) break;
      end
    end
    r_c = cv;
    eat_round(0, r_c, lat);
    probe("stuck_cell_empty", b_c);
    conflict = 1'b0;
    for (int k = 0; k < m_len; k++) if (m_body[k] == r_c) conflict = 1'b1;
    check("linear_not_on_body", conflict, 0);
    repeat (3) tick();

    // Apple 1 eaten while apple 0 respawns; served right after apple 0 commits.
    make_body(10);
    a0 = m_cell[0];
    a1 = m_cell[1];
    set_head(a0);
    r_c = pick_free();
    set_rand(r_c);
    goodColl = 1'b1;
    t = 0; n_eat = 0; t_eat1 = -1; t_eat2 = -1; t_v0 = -1; t_v1 = -1;
    while (t < 400 && t_v1 < 0) begin
      tick();
      t++;
      if (eaten) begin
        n_eat++;
        goodColl = 1'b0;
        if (n_eat == 1) begin
          t_eat1 = t;
          m_valid[0] = 1'b0;
        end else begin
          t_eat2 = t;
          m_valid[1] = 1'b0;
          check("sim_both_invalid", apple_valid, 2'b00);
        end
      end
      if (t_eat1 > 0 && t == t_eat1 + 2) begin
        set_head(a1);
        goodColl = 1'b1;
      end
      if (t_v0 < 0 && n_eat >= 1 && apple_valid[0]) begin
        t_v0 = t;
        m_valid[0] = 1'b1;
        m_cell[0]  = r_c;
        r1_c = pick_free();
        set_rand(r1_c);
      end
      if (t_v0 >= 0 && t_eat2 > 0 && t > t_eat2 && apple_valid[1]) begin
        t_v1 = t;
        m_valid[1] = 1'b1;
        m_cell[1]  = r1_c;
      end
    end
    check("sim_eaten_count", n_eat, 2);
    check("sim_eat_before_commit", (t_eat2 > 0 && t_eat2 < t_v0), 1);
    check("sim_second_served", t_v1 - t_v0, 3 + m_len);
    check("sim_final_valid", apple_valid, 2'b11);
    probe("sim_cell0", r_c);
    probe("sim_cell1", r1_c);
    repeat (3) tick();

    // Restart in the middle of a body scan discards the respawn.
    make_body(8);
    set_head(m_cell[0]);
    r_c = pick_free();
    set_rand(r_c);
    goodColl = 1'b1;
    t = 0;
    while (t < 20 && !eaten) begin
      tick();
      t++;
    end
    check("abort_eaten_seen", eaten, 1);
    goodColl = 1'b0;
    repeat (4) tick();
    check("abort_busy_before", busy, 1);
    s_reset = 1'b1;
    tick();
    check("abort_valid", apple_valid, 2'b11);
    check("abort_busy", busy, 0);
    check("abort_eaten", eaten, 0);
    check("abort_apple", apple, 0);
    s_reset = 1'b0;
    model_reset();
    repeat (20) tick();
    check("abort_no_commit_busy", busy, 0);
    check("abort_no_commit_valid", apple_valid, 2'b11);
    probe("abort_cand_empty", r_c);
    render_scan();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apple_spawner.md
APPLE_SPAWNER -- requirements
Module: apple_spawner

Interface
REQ-001 SHALL have parameter GRID_BITS, default 4, meaning bits per axis; the grid is 2^GRID_BITS x 2^GRID_BITS.
REQ-002 SHALL have parameter MAX_LEN, default 50, meaning number of body segment slots.
REQ-003 SHALL have parameter NUM_APPLES, default 2, meaning simultaneous apples, range 1..8.
REQ-004 SHALL have parameter MAX_RETRY, default 15, meaning random draws per respawn before linear search.
REQ-005 SHALL have parameters INIT_X, default 12, and INIT_Y, default 5, meaning apple 0 reset cell.
REQ-006 SHALL have port clk, input, 1 bit: system clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low.
REQ-008 SHALL have port s_reset, input, 1 bit: synchronous active-high game restart.
REQ-009 SHALL have ports x and y, input, GRID_BITS each: render scan cell.
REQ-010 SHALL have ports head_x and head_y, input, GRID_BITS each: snake head cell.
REQ-011 SHALL have ports randX and randY, input, GRID_BITS each: free-running random source.
REQ-012 SHALL have port goodColl, input, 1 bit: asynchronous head-on-apple level.
REQ-013 SHALL have port body, input, MAX_LEN x 2*GRID_BITS: packed {x,y} per segment.
REQ-014 SHALL have port body_len, input, $clog2(MAX_LEN+1): valid segment count; slots at or above body_len are ignored.
REQ-015 SHALL have port apple, output, 1 bit: scan cell holds a valid apple.
REQ-016 SHALL have port apple_valid, output, NUM_APPLES bits: per-apple present flag.
REQ-017 SHALL have port eaten, output, 1 bit: one-cycle pulse when an apple is consumed.
REQ-018 SHALL have port busy, output, 1 bit: respawn engine not IDLE.

Function
REQ-019 SHALL pass goodColl through the existing 2-flop synchronizer, then a rising-edge detector; total detection latency 3 cycles.
REQ-020 On a detected edge, SHALL, in the following cycle, clear apple_valid[i] for the lowest i whose cell equals {head_x,head_y}, set pending[i], and pulse eaten.
REQ-021 A detected edge matching no valid apple SHALL be ignored: no eaten pulse, no state change.
REQ-022 SHALL run FSM states IDLE, DRAW, SCAN, COMMIT, serving the lowest-index pending apple.
REQ-023 IDLE -> DRAW when pending is nonzero; the retry counter is cleared.
REQ-024 DRAW SHALL latch candidate {randX,randY}, or the previous candidate +1 with wrap over 2^(2*GRID_BITS) once the retry count equals MAX_RETRY, then go to SCAN with index 0.
REQ-025 SCAN SHALL compare the candidate with one body slot per cycle, index 0..body_len-1.
- A match -> DRAW, retry count +1, saturating at MAX_RETRY.
- Index reaching body_len -> COMMIT.
- body_len=0 -> COMMIT after one cycle.
REQ-026 COMMIT SHALL compare the candidate against all other valid apples and the current head in parallel.
- Conflict -> DRAW.
- Otherwise write the cell, set apple_valid, clear pending, and go to IDLE.
REQ-027 Per-attempt latency SHALL be 1 (DRAW) + max(body_len,1) (SCAN) + 1 (COMMIT) cycles.
REQ-028 apple SHALL be registered, 1-cycle latency from x/y, and equal the OR over valid apples of a cell match.
REQ-029 Edges arriving while busy SHALL only set pending bits; there is no loss, and an in-flight respawn is not disturbed.
REQ-030 If the in-flight apple index is re-eaten, which is impossible while it is invalid, the edge SHALL be ignored per REQ-021.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 On reset low or s_reset high at a clock edge, outputs and state SHALL take these values:
- state=IDLE, pending=0, retry=0, apple=0, eaten=0.
- synchronizer flops cleared.
- all apple_valid=1.
- apple i at (INIT_X, (INIT_Y+2i) mod 2^GRID_BITS).
REQ-033 Reset mid-respawn SHALL abort it with no partial commit.

Structure
REQ-034 A shared package snake_pkg SHALL hold:
- the cell typedef {x,y} sized by GRID_BITS;
- the FSM state enum;
- the INIT_X/INIT_Y defaults.
REQ-035 The block SHALL reuse sub-module synchronizer for goodColl; there SHALL be no other sub-modules.

Verification
REQ-036 Reset: reset low for 2 cycles with NUM_APPLES=2 -> apples at (12,5),(12,7), apple_valid=2'b11, busy=0.
REQ-037 Eat: head=(12,5), goodColl 0->1 -> eaten pulse at cycle 4, apple_valid[0]=0, busy=1, body_len=3 -> apple_valid[0]=1 after 5 cycles if the first draw is free.
REQ-038 Conflict: randX/Y fixed on body[2] for 15 draws, then free -> 16th draw uses the linear search, and the committed cell matches no body slot.
REQ-039 Simultaneous: eat apple 1 while apple 0 respawns -> pending=2'b10, apple 1 served right after apple 0 commits, two eaten pulses.
REQ-040 Render: scan x,y over the full grid -> apple=1 exactly at valid apple cells, one cycle delayed.
REQ-041 Abort: s_reset during SCAN -> next cycle shows reset values, no commit.
